// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and constants for master and slave side
package spi_pkg;

  typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, LAG, DONE} spi_mst_st_t;

  localparam int SPI_BITS = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - loadable down-counter timing each bus phase
// phase_end is high while the count sits at zero, i.e. during the final cycle of a phase.
module spi_clkgen #(
  parameter int CW = 3
) (
  input  logic          Clk_i,
  input  logic          Rst_ni,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          phase_end
);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte mode-0 SPI master, MSB first, one-hot active-high ss
// SPI_MASTER_LOOPBACK_EN adds loopback_i, which makes rx sample the outgoing mosi bit.
module spi_master
  import spi_pkg::*;
#(
  parameter  int NSLAVES  = 2,
  parameter  int HALF_PER = 4,
  parameter  int SS_LEAD  = 4,
  parameter  int SS_LAG   = 4,
  localparam int SW       = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
  input  logic               Clk_i,
  input  logic               Rst_ni,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic               loopback_i,
`endif
  input  logic               start_i,
  input  logic [SW-1:0]      slv_sel_i,
  input  logic [7:0]         tx_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [7:0]         rx_data_o,
  output logic               sck_o,
  output logic               mosi_o,
  input  logic               miso_i,
  output logic [NSLAVES-1:0] ss_o
);

  localparam int CW = $clog2(max3(HALF_PER, SS_LEAD, SS_LAG) + 1);
  localparam int BW = $clog2(SPI_BITS);

  localparam logic [CW-1:0] LEAD_M1 = CW'(SS_LEAD - 1);
  localparam logic [CW-1:0] HP_M1   = CW'(HALF_PER - 1);
  localparam logic [CW-1:0] LAG_M1  = CW'(SS_LAG - 1);
  localparam logic [SW:0]   NSL     = (SW + 1)'(NSLAVES);
  localparam logic [BW-1:0] LAST    = BW'(SPI_BITS - 1);

  spi_mst_st_t         state;
  logic [SPI_BITS-2:0] tx_sh;
  logic [SPI_BITS-1:0] rx_sh;
  logic [BW-1:0]       bitcnt;
  logic                sel_ok;
  logic                last_bit;
  logic                rx_bit;
  logic                phase_end;
  logic                cg_load;
  logic [CW-1:0]       cg_val;

  assign sel_ok   = ({1'b0, slv_sel_i} < NSL);
  assign last_bit = (bitcnt == LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback_i ? mosi_o : miso_i;
`else
  assign rx_bit = miso_i;
`endif

  // Counter is reloaded on every phase change with the length of the phase being entered.
  always_comb begin
    cg_load = 1'b0;
    cg_val  = '0;
    case (state)
      IDLE: begin
        if (start_i && sel_ok) begin
          cg_load = 1'b1;
          cg_val  = LEAD_M1;
        end
      end
      LEAD, LOW: begin
        if (phase_end) begin
          cg_load = 1'b1;
          cg_val  = HP_M1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          cg_load = 1'b1;
          cg_val  = last_bit ? LAG_M1 : HP_M1;
        end
      end
      LAG: begin
        cg_load = phase_end;
      end
      default: ;
    endcase
  end

  spi_clkgen #(.CW(CW)) u_clkgen (
    .Clk_i     (Clk_i),
    .Rst_ni    (Rst_ni),
    .load      (cg_load),
    .load_val  (cg_val),
    .phase_end (phase_end)
  );

  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      state     <= IDLE;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bitcnt    <= '0;
      sck_o     <= 1'b0;
      mosi_o    <= 1'b0;
      ss_o      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rx_data_o <= 8'h00;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && sel_ok) begin
            tx_sh  <= tx_data_i[SPI_BITS-2:0];
            mosi_o <= tx_data_i[SPI_BITS-1];
            bitcnt <= '0;
            busy_o <= 1'b1;
            for (int i = 0; i < NSLAVES; i++) begin
              ss_o[i] <= (slv_sel_i == SW'(i));
            end
            state <= LEAD;
          end
        end
        LEAD: begin
          if (phase_end) state <= LOW;
        end
        LOW: begin
          if (phase_end) begin
            sck_o <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          // miso is taken on the edge that drops sck, before the slave shifts its next bit.
          if (phase_end) begin
            sck_o  <= 1'b0;
            rx_sh  <= {rx_sh[SPI_BITS-2:0], rx_bit};
            mosi_o <= tx_sh[SPI_BITS-2];
            tx_sh  <= {tx_sh[SPI_BITS-3:0], 1'b0};
            bitcnt <= bitcnt + 1'b1;
            state  <= last_bit ? LAG : LOW;
          end
        end
        LAG: begin
          if (phase_end) begin
            ss_o      <= '0;
            mosi_o    <= 1'b0;
            rx_data_o <= rx_sh;
            done_o    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a behavioural slave model
// Loopback scenario is compiled only when SPI_MASTER_LOOPBACK_EN is defined.
module tb_spi_master;

  localparam int LAT = 1 + 4 + 16 * 4 + 4 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [0:0] sel = '0;
  logic [7:0] tx = '0;
  logic       loopback = 1'b0;
  logic       busy, done, sck, mosi, miso;
  logic [7:0] rx;
  logic [1:0] ss;

  logic       start3 = 1'b0;
  logic [1:0] sel3 = '0;
  logic       busy3, done3, sck3, mosi3;
  logic [7:0] rx3;
  logic [2:0] ss3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master dut (
    .Clk_i(clk), .Rst_ni(rst_n),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback_i(loopback),
`endif
    .start_i(start), .slv_sel_i(sel), .tx_data_i(tx), .busy_o(busy), .done_o(done),
    .rx_data_o(rx), .sck_o(sck), .mosi_o(mosi), .miso_i(miso), .ss_o(ss)
  );

  spi_master #(.NSLAVES(3)) dut3 (
    .Clk_i(clk), .Rst_ni(rst_n),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback_i(1'b0),
`endif
    .start_i(start3), .slv_sel_i(sel3), .tx_data_i(8'hE7), .busy_o(busy3), .done_o(done3),
    .rx_data_o(rx3), .sck_o(sck3), .mosi_o(mosi3), .miso_i(1'b0), .ss_o(ss3)
  );

  // Slave model: presents the response MSB first, advancing one bit per sck fall.
  logic [7:0] resp_q[$];
  logic [7:0] cur_resp = 8'h00;
  int         falls = 0;
  wire        ss_any = |ss;

  always @(posedge ss_any) begin
    cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
    falls = 0;
  end
  always @(negedge sck) falls = falls + 1;
  assign miso = (ss_any && falls < 8) ? cur_resp[7 - falls] : 1'bz;

  logic       mosi_q[$];
  logic [1:0] ss_or = '0;
  int         sck_no_ss = 0;
  int         done_cnt = 0;
  logic [2:0] ss3_or = '0;

  always @(posedge sck) begin
    mosi_q.push_back(mosi);
    ss_or = ss_or | ss;
    if (ss == 2'b00) sck_no_ss++;
  end
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [7:0] mosi_byte(input int base);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) if (base + i < mosi_q.size()) b = {b[6:0], mosi_q[base + i]};
    return b;
  endfunction

  task automatic clear_mon();
    mosi_q.delete();
    ss_or = '0;
    sck_no_ss = 0;
  endtask

  task automatic do_xfer(input logic [0:0] s, input logic [7:0] t, input logic [7:0] r,
                         input int poke_bit, input int abort_bit,
                         output int lat, output logic tmo);
    logic poked = 1'b0;
    resp_q.push_back(r);
    clear_mon();
    @(negedge clk);
    start = 1'b1; sel = s; tx = t; lat = 1;
    @(posedge clk); lat++; #1;
    start = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done) begin tmo = 1'b0; break; end
      if (abort_bit >= 0 && mosi_q.size() == abort_bit) begin tmo = 1'b0; break; end
      if (poke_bit >= 0 && !poked && mosi_q.size() == poke_bit) begin
        start = 1'b1; tx = 8'hFF; poked = 1'b1;
      end
      @(posedge clk); lat++; #1;
      start = 1'b0; tx = t;
    end
    if (done) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sck, mosi, ss, busy, done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=000000", {sck, mosi, ss, busy, done});
    end
    n_checks++;
    if (rx !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h want=00", rx); end
    n_checks++;
    if ({ss3, busy3, done3, rx3} !== 13'b0) begin
      n_fail++; $display("FAIL reset_dut3 got=%b want=0", {ss3, busy3, done3, rx3});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int lat; logic tmo; int d0;
    d0 = done_cnt;
    do_xfer(1'b0, 8'hA5, 8'h3C, -1, -1, lat, tmo);
    n_checks++;
    if (tmo) begin n_fail++; $display("FAIL basic_timeout got=timeout want=done"); end
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
    n_checks++;
    if (rx !== 8'h3C) begin n_fail++; $display("FAIL basic_rx got=%h want=3c", rx); end
    n_checks++;
    if (mosi_q.size() != 8 || mosi_byte(0) !== 8'hA5) begin
      n_fail++; $display("FAIL basic_mosi got=%h/%0d rises want=a5/8", mosi_byte(0), mosi_q.size());
    end
    n_checks++;
    if (ss_or !== 2'b01 || sck_no_ss != 0) begin
      n_fail++; $display("FAIL basic_ss got=%b/%0d want=01/0", ss_or, sck_no_ss);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done got=%0d pulses busy=%b want=1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_random();
    int lat; logic tmo;
    logic [0:0] s; logic [7:0] t, r;
    for (int k = 0; k < 6; k++) begin
      s = 1'($urandom_range(0, 1)); t = 8'($urandom); r = 8'($urandom);
      do_xfer(s, t, r, -1, -1, lat, tmo);
      n_checks++;
      if (tmo || lat != LAT) begin
        n_fail++; $display("FAIL rand%0d_latency got=%0d tmo=%b want=%0d", k, lat, tmo, LAT);
      end
      n_checks++;
      if (rx !== r) begin n_fail++; $display("FAIL rand%0d_rx got=%h want=%h", k, rx, r); end
      n_checks++;
      if (mosi_q.size() != 8 || mosi_byte(0) !== t) begin
        n_fail++; $display("FAIL rand%0d_mosi got=%h want=%h", k, mosi_byte(0), t);
      end
      n_checks++;
      if (ss_or !== (s ? 2'b10 : 2'b01) || sck_no_ss != 0) begin
        n_fail++; $display("FAIL rand%0d_ss got=%b want=%b", k, ss_or, (s ? 2'b10 : 2'b01));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1, r2;
    logic [7:0] got[2];
    int c = 0, fall_c = -1, rise_c = -1, ndone = 0;
    logic prev_any = 1'b0;
    r1 = 8'($urandom); r2 = 8'($urandom);
    got[0] = 8'h00; got[1] = 8'h00;
    resp_q.push_back(r1); resp_q.push_back(r2);
    clear_mon();
    @(negedge clk);
    start = 1'b1; sel = 1'b1; tx = 8'h01;
    for (int i = 0; i < 400 && ndone < 2; i++) begin
      @(posedge clk); c++; #1;
      if (busy) tx = 8'h80;
      if (prev_any && ss == 2'b00 && fall_c < 0) fall_c = c;
      if (!prev_any && ss != 2'b00 && fall_c >= 0 && rise_c < 0) begin rise_c = c; start = 1'b0; end
      if (done) begin got[ndone] = rx; ndone++; end
      prev_any = |ss;
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ndone != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d want=2", ndone); end
    n_checks++;
    if (got[0] !== r1 || got[1] !== r2) begin
      n_fail++; $display("FAIL b2b_rx got=%h,%h want=%h,%h", got[0], got[1], r1, r2);
    end
    n_checks++;
    if (rise_c < 0 || rise_c - fall_c < 2) begin
      n_fail++; $display("FAIL b2b_ss_gap got=%0d want>=2", rise_c - fall_c);
    end
    n_checks++;
    if (mosi_q.size() != 16 || mosi_byte(0) !== 8'h01 || mosi_byte(8) !== 8'h80) begin
      n_fail++; $display("FAIL b2b_mosi got=%h,%h/%0d want=01,80/16", mosi_byte(0), mosi_byte(8), mosi_q.size());
    end
    n_checks++;
    if (ss_or !== 2'b10 || sck_no_ss != 0) begin
      n_fail++; $display("FAIL b2b_ss got=%b want=10", ss_or);
    end
  endtask

  task automatic test_ignore_start();
    int lat; logic tmo; int d0;
    logic [7:0] t, r, held;
    t = 8'($urandom) & 8'h7F; r = 8'($urandom);
    do_xfer(1'b0, t, r, 4, -1, lat, tmo);
    n_checks++;
    if (tmo || lat != LAT) begin n_fail++; $display("FAIL ign_latency got=%0d want=%0d", lat, LAT); end
    n_checks++;
    if (mosi_byte(0) !== t || rx !== r) begin
      n_fail++; $display("FAIL ign_data got=%h/%h want=%h/%h", mosi_byte(0), rx, t, r);
    end
    d0 = done_cnt; held = rx;
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0 || rx !== held || busy !== 1'b0 || mosi_q.size() != 8) begin
      n_fail++; $display("FAIL ign_not_queued got=%0d pulses rx=%h busy=%b want=0 rx=%h busy=0", done_cnt - d0, rx, busy, held);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic tmo; int d0;
    logic [7:0] r;
    d0 = done_cnt;
    do_xfer(1'b0, 8'($urandom), 8'($urandom), -1, 4, lat, tmo);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (sck !== 1'b0 || ss !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abort got=sck%b ss%b busy%b want=0 00 0", sck, ss, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt - d0); end
    r = 8'($urandom);
    do_xfer(1'b0, 8'h5A, r, -1, -1, lat, tmo);
    n_checks++;
    if (tmo || lat != LAT || rx !== r || mosi_byte(0) !== 8'h5A) begin
      n_fail++; $display("FAIL rstmid_fresh got=lat%0d rx%h mosi%h want=lat%0d rx%h mosi5a", lat, rx, mosi_byte(0), LAT, r);
    end
  endtask

  task automatic test_bad_sel();
    int bad = 0, ok = 0;
    @(negedge clk); start3 = 1'b1; sel3 = 2'd3;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ss3 != 3'b000 || busy3 || done3) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL badsel_ignored got=%0d active cycles want=0", bad); end
    ss3_or = '0;
    @(negedge clk); start3 = 1'b1; sel3 = 2'd2;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      @(posedge clk); #1;
      ss3_or = ss3_or | ss3;
      if (done3) ok = 1;
    end
    n_checks++;
    if (ok != 1 || ss3_or !== 3'b100 || rx3 !== 8'h00) begin
      n_fail++; $display("FAIL sel2_xfer got=done%0d ss%b rx%h want=done1 ss100 rx00", ok, ss3_or, rx3);
    end
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    int lat; logic tmo;
    loopback = 1'b1;
    do_xfer(1'b1, 8'hC3, 8'h3C, -1, -1, lat, tmo);
    loopback = 1'b0;
    n_checks++;
    if (tmo || rx !== 8'hC3) begin n_fail++; $display("FAIL loopback_rx got=%h want=c3", rx); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_bad_sel();
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
